pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage RISC-V pipeline. Merges three stall sources into one consistent set of per-stage pipeline-register controls and the PC write enable:
- the load-use request from the hazard detection unit;
- the ID-stage branch-taken flush;
- a multi-cycle data-memory handshake.

It also handles start-up gating, a memory-timeout lockout and a saturating stall-cycle counter for performance checks.

---
 rtl/pipeline_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five-stage pipeline.
// Merges load-use, ID branch-taken and data-memory wait into per-stage
// pipeline-register controls. Outputs are Mealy-decoded from state and
// inputs; state and counters advance on the rising clock edge.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_i,
  input  logic             branch_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             memwb_write_o,
  output logic             memwb_bubble_o,
  output logic             mem_en_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             tmo_clr;
  logic             tmo_inc;
  logic             tmo_hit;
  logic             stall_inc;

  // Timeout reached if this ack-less cycle is the TIMEOUT-th in a row
  assign tmo_hit = ((tmo_cnt + CNT_ONE) == TMO_LIMIT);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and timeout-counter control
  always_comb begin
    state_next = state;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!start_i) begin
          state_next = IDLE;
        end else if (mem_req_i) begin
          state_next = MEM_WAIT;
          tmo_clr    = 1'b1;
        end
      end
      MEM_WAIT: begin
        // An ack always wins, even on the cycle the timeout would expire
        if (mem_ack_i) begin
          state_next = RUN;
        end else begin
          tmo_inc = 1'b1;
          if (tmo_hit) begin
            state_next = ERROR;
          end
        end
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode (Mealy): enables default off, bubbles/flushes default off
  always_comb begin
    pc_write_o     = 1'b0;
    ifid_write_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_write_o  = 1'b0;
    memwb_write_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    mem_en_o       = 1'b0;
    error_o        = 1'b0;
    case (state)
      IDLE: begin
        memwb_bubble_o = 1'b1;
      end
      RUN: begin
        if (!start_i) begin
          // Pipeline halts; everything stays disabled
        end else if (mem_req_i) begin
          // Memory op dominates: freeze upstream, bubble into MEM/WB
          memwb_bubble_o = 1'b1;
          mem_en_o       = 1'b1;
        end else begin
          exmem_write_o = 1'b1;
          memwb_write_o = 1'b1;
          if (hazard_i) begin
            // Load-use: hold IF/ID and PC, inject NOP into ID/EX
            idex_write_o  = 1'b1;
            idex_bubble_o = 1'b1;
          end else begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            idex_write_o  = 1'b1;
            ifid_flush_o  = branch_i;
          end
        end
      end
      MEM_WAIT: begin
        mem_en_o = 1'b1;
        if (mem_ack_i) begin
          // Data valid: drain MEM, front end follows hazard/branch rules
          exmem_write_o = 1'b1;
          memwb_write_o = 1'b1;
          if (hazard_i) begin
            idex_write_o  = 1'b1;
            idex_bubble_o = 1'b1;
          end else begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            idex_write_o  = 1'b1;
            ifid_flush_o  = branch_i;
          end
        end else begin
          memwb_bubble_o = 1'b1;
        end
      end
      ERROR: begin
        memwb_bubble_o = 1'b1;
        error_o        = 1'b1;
      end
      default: begin
        memwb_bubble_o = 1'b1;
      end
    endcase
  end

  // Memory timeout counter: cleared on request, counts ack-less waits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
    end else if (tmo_clr) begin
      tmo_cnt <= '0;
    end else if (tmo_inc) begin
      tmo_cnt <= tmo_cnt + CNT_ONE;
    end
  end

  // Stall cycles are those in RUN/MEM_WAIT where the PC does not advance
  assign stall_inc = ((state == RUN) || (state == MEM_WAIT)) && !pc_write_o;

  // Saturating stall-cycle counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       hazard;
  logic       branch;
  logic       mem_req;
  logic       mem_ack;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_bubble;
  logic       exmem_write;
  logic       memwb_write;
  logic       memwb_bubble;
  logic       mem_en;
  logic       error;
  logic [3:0] stall_cnt;

  int checks;
  int failures;
  int exp_stall;

  // Output bundle: pc ifid_w ifid_f idex_w idex_b exmem_w memwb_w memwb_b mem_en err
  logic [9:0] outs;
  assign outs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                 exmem_write, memwb_write, memwb_bubble, mem_en, error};

  localparam logic [9:0] O_IDLE = 10'b0000000100;
  localparam logic [9:0] O_RUN  = 10'b1101011000;
  localparam logic [9:0] O_HAZ  = 10'b0001111000;
  localparam logic [9:0] O_BR   = 10'b1111011000;
  localparam logic [9:0] O_FRZ  = 10'b0000000110;
  localparam logic [9:0] O_ACK  = 10'b1101011010;
  localparam logic [9:0] O_ACKH = 10'b0001111010;
  localparam logic [9:0] O_ERR  = 10'b0000000101;
  localparam logic [9:0] O_STOP = 10'b0000000000;

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .hazard_i       (hazard),
    .branch_i       (branch),
    .mem_req_i      (mem_req),
    .mem_ack_i      (mem_ack),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_write_o   (idex_write),
    .idex_bubble_o  (idex_bubble),
    .exmem_write_o  (exmem_write),
    .memwb_write_o  (memwb_write),
    .memwb_bubble_o (memwb_bubble),
    .mem_en_o       (mem_en),
    .error_o        (error),
    .stall_cnt_o    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are then changed 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic h, input logic b,
                        input logic rq, input logic ak);
    start = s; hazard = h; branch = b; mem_req = rq; mem_ack = ak;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    exp_stall = 0;
  endtask

  task automatic go_run();
    set_in(1, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    if (outs !== O_IDLE) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, O_IDLE); end
    checks++;
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    checks++;
    step();
    rst = 1'b0;
    exp_stall = 0;
    for (int c = 0; c < 4; c++) begin
      set_in((c == 3) ? 1'b1 : 1'b0, 0, 0, 0, 0);
      if (outs !== O_IDLE) begin failures++; $display("FAIL idle_cyc%0d got=%b exp=%b", c, outs, O_IDLE); end
      checks++;
      step();
    end
    set_in(1, 0, 0, 0, 0);
    if (outs !== O_RUN) begin failures++; $display("FAIL run_after_start got=%b exp=%b", outs, O_RUN); end
    checks++;
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL run_stall0 got=%0d exp=0", stall_cnt); end
    checks++;
  endtask

  task automatic test_hazard_branch();
    set_in(1, 1, 1, 0, 0);
    if (outs !== O_HAZ) begin failures++; $display("FAIL hazard_beats_branch got=%b exp=%b", outs, O_HAZ); end
    checks++;
    step();
    exp_stall++;
    set_in(1, 0, 0, 0, 0);
    if (outs !== O_RUN) begin failures++; $display("FAIL run_after_hazard got=%b exp=%b", outs, O_RUN); end
    checks++;
    if (stall_cnt !== 4'(exp_stall)) begin failures++; $display("FAIL stall_after_hazard got=%0d exp=%0d", stall_cnt, exp_stall); end
    checks++;
    set_in(1, 0, 1, 0, 0);
    if (outs !== O_BR) begin failures++; $display("FAIL branch_flush got=%b exp=%b", outs, O_BR); end
    checks++;
    step();
    set_in(1, 0, 0, 0, 1);
    if (outs !== O_RUN) begin failures++; $display("FAIL ack_ignored_in_run got=%b exp=%b", outs, O_RUN); end
    checks++;
    if (stall_cnt !== 4'(exp_stall)) begin failures++; $display("FAIL stall_after_branch got=%0d exp=%0d", stall_cnt, exp_stall); end
    checks++;
  endtask

  // Three ack-less waits, ack on the 4th (the cycle the timeout would hit)
  task automatic test_mem_wait();
    set_in(1, 1, 1, 1, 0);
    if (outs !== O_FRZ) begin failures++; $display("FAIL mem_req_freeze got=%b exp=%b", outs, O_FRZ); end
    checks++;
    step();
    exp_stall++;
    for (int w = 0; w < 3; w++) begin
      set_in(1, 0, 0, 0, 0);
      if (outs !== O_FRZ) begin failures++; $display("FAIL mem_wait%0d got=%b exp=%b", w, outs, O_FRZ); end
      checks++;
      step();
      exp_stall++;
    end
    set_in(1, 0, 0, 0, 1);
    if (outs !== O_ACK) begin failures++; $display("FAIL mem_ack_at_limit got=%b exp=%b", outs, O_ACK); end
    checks++;
    step();
    set_in(1, 0, 0, 0, 0);
    if (outs !== O_RUN) begin failures++; $display("FAIL run_after_ack got=%b exp=%b", outs, O_RUN); end
    checks++;
    if (stall_cnt !== 4'(exp_stall)) begin failures++; $display("FAIL stall_after_mem got=%0d exp=%0d", stall_cnt, exp_stall); end
    checks++;
  endtask

  task automatic test_back_to_back();
    set_in(1, 0, 0, 1, 0);
    step();
    exp_stall++;
    // ack with hazard and a new request: request is not consulted yet
    set_in(1, 1, 0, 1, 1);
    if (outs !== O_ACKH) begin failures++; $display("FAIL b2b_ack_hazard got=%b exp=%b", outs, O_ACKH); end
    checks++;
    step();
    exp_stall++;
    set_in(1, 0, 0, 1, 0);
    if (outs !== O_FRZ) begin failures++; $display("FAIL b2b_reenter got=%b exp=%b", outs, O_FRZ); end
    checks++;
    step();
    exp_stall++;
    set_in(1, 0, 1, 0, 1);
    if (outs !== (O_ACK | 10'b0010000000)) begin failures++; $display("FAIL b2b_ack_branch got=%b exp=%b", outs, O_ACK | 10'b0010000000); end
    checks++;
    step();
    set_in(1, 0, 0, 0, 0);
    if (outs !== O_RUN) begin failures++; $display("FAIL b2b_run got=%b exp=%b", outs, O_RUN); end
    checks++;
    if (stall_cnt !== 4'(exp_stall)) begin failures++; $display("FAIL b2b_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
    checks++;
  endtask

  task automatic test_start_drop();
    set_in(1, 0, 0, 1, 0);
    step();
    exp_stall++;
    set_in(0, 0, 0, 0, 0);
    if (outs !== O_FRZ) begin failures++; $display("FAIL drop_in_wait got=%b exp=%b", outs, O_FRZ); end
    checks++;
    step();
    exp_stall++;
    set_in(0, 0, 0, 0, 1);
    if (outs !== O_ACK) begin failures++; $display("FAIL drop_ack got=%b exp=%b", outs, O_ACK); end
    checks++;
    step();
    set_in(0, 0, 0, 0, 0);
    if (outs !== O_STOP) begin failures++; $display("FAIL run_stop got=%b exp=%b", outs, O_STOP); end
    checks++;
    step();
    exp_stall++;
    set_in(0, 0, 0, 0, 0);
    if (outs !== O_IDLE) begin failures++; $display("FAIL back_to_idle got=%b exp=%b", outs, O_IDLE); end
    checks++;
    step();
    if (stall_cnt !== 4'(exp_stall)) begin failures++; $display("FAIL idle_stall_hold got=%0d exp=%0d", stall_cnt, exp_stall); end
    checks++;
  endtask

  task automatic test_timeout();
    do_reset();
    go_run();
    set_in(1, 0, 0, 1, 0);
    step();
    for (int w = 0; w < 4; w++) begin
      set_in(1, 0, 0, 0, 0);
      if (outs !== O_FRZ) begin failures++; $display("FAIL tmo_wait%0d got=%b exp=%b", w, outs, O_FRZ); end
      checks++;
      step();
    end
    for (int e = 0; e < 4; e++) begin
      set_in(e[0], e[1], 0, e[0], 1);
      if (outs !== O_ERR) begin failures++; $display("FAIL error_sticky%0d got=%b exp=%b", e, outs, O_ERR); end
      checks++;
      step();
    end
    if (stall_cnt !== 4'd5) begin failures++; $display("FAIL error_stall_hold got=%0d exp=5", stall_cnt); end
    checks++;
    rst = 1'b1;
    #1;
    if (outs !== O_IDLE) begin failures++; $display("FAIL reset_from_error got=%b exp=%b", outs, O_IDLE); end
    checks++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    go_run();
    set_in(1, 0, 0, 1, 0);
    step();
    set_in(1, 0, 0, 0, 0);
    if (mem_en !== 1'b1) begin failures++; $display("FAIL mem_en_before_rst got=%b exp=1", mem_en); end
    checks++;
    #2;
    rst = 1'b1;
    mem_ack = 1'b1;
    #1;
    if (outs !== O_IDLE) begin failures++; $display("FAIL async_rst_outs got=%b exp=%b", outs, O_IDLE); end
    checks++;
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL async_rst_stall got=%0d exp=0", stall_cnt); end
    checks++;
    step();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 1);
    step();
    if (outs !== O_IDLE) begin failures++; $display("FAIL idle_after_rst got=%b exp=%b", outs, O_IDLE); end
    checks++;
  endtask

  task automatic test_saturation();
    do_reset();
    go_run();
    set_in(1, 1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (stall_cnt !== 4'((i > 15) ? 15 : i)) begin
        failures++;
        $display("FAIL stall_sat_%0d got=%0d exp=%0d", i, stall_cnt, (i > 15) ? 15 : i);
      end
      checks++;
    end
    if (outs !== O_HAZ) begin failures++; $display("FAIL sat_hazard_outs got=%b exp=%b", outs, O_HAZ); end
    checks++;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_stall = 0;
    rst = 1'b1;
    start = 1'b0; hazard = 1'b0; branch = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    test_reset();
    test_hazard_branch();
    test_mem_wait();
    test_back_to_back();
    test_start_drop();
    test_timeout();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
